cache_line_xfer: RTL

Line-transfer engine between the data cache and the byte-addressable data memory (dmem).
- On a cache miss, it optionally writes back one dirty line, then fills one line.
- Each line is moved as WORDS_PER_LINE sequential word beats, using dmem's we/re/HSEL/a/wd/HSIZE/rd/Valid interface.
- The cache sees a single request/done handshake and a whole-line data bus.

---
 rtl/leg_mem_pkg.sv | 24 ++
 rtl/line_beat_ctr.sv | 47 ++++
 rtl/cache_line_xfer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/leg_mem_pkg.sv
// Shared definitions for the cache-to-dmem line transfer path: transfer
// size encodings, the transfer state type and line address alignment.
package leg_mem_pkg;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } xfer_state_t;

  // Clear the byte-offset bits of an address for a line of 'words' 32-bit words.
  // 'words' is a power of two, so the line size in bytes minus one is the offset mask.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned words);
    logic [31:0] w_mask;
    w_mask = ~((32'(words) * 32'd4) - 32'd1);
    return addr & w_mask;
  endfunction

endpackage

// File: rtl/line_beat_ctr.sv
// Word beat counter within one cache line. Wraps to zero after the last
// word, exposes the value it will take at the next edge so the owner can
// register bus outputs one cycle ahead.
module line_beat_ctr #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned BW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [BW-1:0] o_beat,
  output logic [BW-1:0] o_beat_nxt,
  output logic          o_last
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

  logic [BW-1:0] r_beat;
  logic [BW-1:0] w_beat_nxt;

  // Next beat: clear wins, then advance on a completed beat, else hold
  always_comb begin
    w_beat_nxt = r_beat;
    if (i_clr) begin
      w_beat_nxt = {BW{1'b0}};
    end else if (i_en) begin
      w_beat_nxt = r_beat + BW'(1);
    end else begin
      w_beat_nxt = r_beat;
    end
  end

  // Beat register with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_beat <= {BW{1'b0}};
    end else begin
      r_beat <= w_beat_nxt;
    end
  end

  assign o_beat     = r_beat;
  assign o_beat_nxt = w_beat_nxt;
  assign o_last     = (r_beat == LAST_BEAT);

endmodule

// File: rtl/cache_line_xfer.sv
// Line transfer engine between the data cache and dmem: optional dirty
// line writeback followed by an optional line fill, one word per beat.
// All bus outputs are registered from the next-state values so they are
// glitch-free and line up with the beat they describe.
module cache_line_xfer
  import leg_mem_pkg::*;
#(
  parameter  int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned LINE_W         = 32 * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              do_wb,
  input  logic              do_fill,
  input  logic [31:0]       wb_addr,
  input  logic [31:0]       fill_addr,
  input  logic [LINE_W-1:0] wb_data,
  output logic              busy,
  output logic              done,
  output logic [LINE_W-1:0] fill_data,
  output logic              HSEL,
  output logic              we,
  output logic              re,
  output logic [31:0]       a,
  output logic [31:0]       wd,
  output logic [2:0]        HSIZE,
  input  logic [31:0]       rd,
  input  logic              Valid
);

  localparam int unsigned BW = $clog2(WORDS_PER_LINE);

  xfer_state_t       r_state;
  xfer_state_t       w_state_nxt;

  logic              r_do_fill;
  logic [31:0]       r_wb_line;
  logic [31:0]       r_fill_line;
  logic [LINE_W-1:0] r_wb_data;

  logic              r_busy;
  logic              r_done;
  logic              r_we;
  logic              r_re;
  logic [31:0]       r_a;
  logic [31:0]       r_wd;
  logic [LINE_W-1:0] r_fill_data;

  logic              w_accept;
  logic              w_adv;
  logic              w_last;
  logic [BW-1:0]     w_beat;
  logic [BW-1:0]     w_beat_nxt;
  logic              w_do_fill_src;
  logic [31:0]       w_wb_line_src;
  logic [31:0]       w_fill_line_src;
  logic [LINE_W-1:0] w_wb_data_src;
  logic [31:0]       w_offset;
  logic [31:0]       w_a_nxt;
  logic [31:0]       w_wd_nxt;

  // A request is only looked at while idle; a beat advances on Valid while moving data
  assign w_accept = (r_state == IDLE) && req;
  assign w_adv    = ((r_state == WB) || (r_state == FILL)) && Valid;

  line_beat_ctr #(
    .WORDS (WORDS_PER_LINE)
  ) u_beat_ctr (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (w_adv),
    .i_clr      (w_accept),
    .o_beat     (w_beat),
    .o_beat_nxt (w_beat_nxt),
    .o_last     (w_last)
  );

  // Request fields: live inputs on the accepting edge, latched copies afterwards
  always_comb begin
    w_do_fill_src   = r_do_fill;
    w_wb_line_src   = r_wb_line;
    w_fill_line_src = r_fill_line;
    w_wb_data_src   = r_wb_data;
    if (w_accept) begin
      w_do_fill_src   = do_fill;
      w_wb_line_src   = line_base(wb_addr, WORDS_PER_LINE);
      w_fill_line_src = line_base(fill_addr, WORDS_PER_LINE);
      w_wb_data_src   = wb_data;
    end else begin
      w_do_fill_src   = r_do_fill;
      w_wb_line_src   = r_wb_line;
      w_fill_line_src = r_fill_line;
      w_wb_data_src   = r_wb_data;
    end
  end

  // Next-state decode: writeback first, then fill, then a one-cycle DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (do_wb) begin
            w_state_nxt = WB;
          end else if (do_fill) begin
            w_state_nxt = FILL;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WB: begin
        if (Valid && w_last) begin
          if (w_do_fill_src) begin
            w_state_nxt = FILL;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_state_nxt = WB;
        end
      end
      FILL: begin
        if (Valid && w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = FILL;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address and write data for the beat that will be on the bus next cycle;
  // offset is OR-ed into the aligned base so it never carries out of the line
  always_comb begin
    w_offset = 32'(w_beat_nxt) << 2;
    w_a_nxt  = 32'd0;
    w_wd_nxt = 32'd0;
    case (w_state_nxt)
      WB: begin
        w_a_nxt  = w_wb_line_src | w_offset;
        w_wd_nxt = w_wb_data_src[32*w_beat_nxt +: 32];
      end
      FILL: begin
        w_a_nxt  = w_fill_line_src | w_offset;
        w_wd_nxt = 32'd0;
      end
      default: begin
        w_a_nxt  = 32'd0;
        w_wd_nxt = 32'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the request when accepted so later input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_do_fill   <= 1'b0;
      r_wb_line   <= 32'd0;
      r_fill_line <= 32'd0;
      r_wb_data   <= {LINE_W{1'b0}};
    end else if (w_accept) begin
      r_do_fill   <= w_do_fill_src;
      r_wb_line   <= w_wb_line_src;
      r_fill_line <= w_fill_line_src;
      r_wb_data   <= w_wb_data_src;
    end
  end

  // Registered status and bus outputs, derived from where the FSM is going
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_a    <= 32'd0;
      r_wd   <= 32'd0;
    end else begin
      r_busy <= (w_state_nxt == WB) || (w_state_nxt == FILL);
      r_done <= (w_state_nxt == DONE);
      r_we   <= (w_state_nxt == WB);
      r_re   <= (w_state_nxt == FILL);
      r_a    <= w_a_nxt;
      r_wd   <= w_wd_nxt;
    end
  end

  // Capture read data word by word; untouched otherwise so the last fill stays visible
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fill_data <= {LINE_W{1'b0}};
    end else if ((r_state == FILL) && Valid) begin
      r_fill_data[32*w_beat +: 32] <= rd;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign we        = r_we;
  assign re        = r_re;
  assign HSEL      = r_we | r_re;
  assign a         = r_a;
  assign wd        = r_wd;
  assign HSIZE     = HSIZE_WORD;
  assign fill_data = r_fill_data;

endmodule
